tcp_conn_ctrl: RTL

// Single-connection TCP server controller downstream of the TCP header decoder. On each

---
 rtl/tcp_conn_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/tcp_conn_ctrl.sv
// Single-connection TCP server controller: runs the connection FSM per decoded segment,
// steers payload commit/discard and schedules one response header to the transmit path.
module tcp_conn_ctrl #(
    parameter logic [15:0]  LOCAL_PORT     = 16'd80,
    parameter logic [31:0]  ISS            = 32'h0000_1000,
    parameter int unsigned  TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_done,
    input  logic        rx_err,
    input  logic [31:0] rx_src_ip,
    input  logic [15:0] rx_source_port,
    input  logic [15:0] rx_dest_port,
    input  logic [31:0] rx_seq,
    input  logic [31:0] rx_ack,
    input  logic [7:0]  rx_flags,
    input  logic [15:0] rx_data_len,
    output logic        rx_commit,
    output logic        rx_discard,
    input  logic        app_tx_valid,
    input  logic [15:0] app_tx_len,
    output logic        app_tx_ready,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_flags,
    output logic [31:0] tx_seq,
    output logic [31:0] tx_ack_num,
    output logic [31:0] tx_dest_ip,
    output logic [15:0] tx_dest_port,
    output logic [15:0] tx_len,
    output logic [2:0]  conn_state
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] F_FIN = 8'h01;
    localparam logic [7:0] F_SYN = 8'h02;
    localparam logic [7:0] F_PSH = 8'h08;
    localparam logic [7:0] F_ACK = 8'h10;

    typedef enum logic [2:0] {
        LISTEN      = 3'd0,
        SYN_RCVD    = 3'd1,
        ESTABLISHED = 3'd2,
        LAST_ACK    = 3'd3
    } state_t;

    typedef struct packed {
        logic [7:0]  flags;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [31:0] ip;
        logic [15:0] port;
        logic [15:0] len;
    } hdr_t;

    state_t        state_q, state_d;
    hdr_t          hdr_q, hdr_d;
    logic          txv_q, txv_d;
    logic [31:0]   snd_q, snd_d, rcv_q, rcv_d, rcv_tmp;
    logic [31:0]   peer_ip_q, peer_ip_d;
    logic [15:0]   peer_port_q, peer_port_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          commit_q, commit_d, discard_q, discard_d, app_rdy_q, app_rdy_d;
    logic          rx_done_q, seg_evt, go_listen, est, timed;
    logic          f_fin, f_syn, f_rst, f_ack;
    logic          unused_flags;

    assign unused_flags = ^rx_flags[7:5] ^ rx_flags[3];
    assign f_fin   = rx_flags[0];
    assign f_syn   = rx_flags[1];
    assign f_rst   = rx_flags[2];
    assign f_ack   = rx_flags[4];
    assign seg_evt = rx_done & ~rx_done_q;
    assign timed   = (state_q == SYN_RCVD) || (state_q == LAST_ACK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LISTEN;
            hdr_q       <= '0;
            txv_q       <= 1'b0;
            snd_q       <= ISS;
            rcv_q       <= '0;
            peer_ip_q   <= '0;
            peer_port_q <= '0;
            timer_q     <= '0;
            commit_q    <= 1'b0;
            discard_q   <= 1'b0;
            app_rdy_q   <= 1'b0;
            rx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            txv_q       <= txv_d;
            snd_q       <= snd_d;
            rcv_q       <= rcv_d;
            peer_ip_q   <= peer_ip_d;
            peer_port_q <= peer_port_d;
            timer_q     <= timer_d;
            commit_q    <= commit_d;
            discard_q   <= discard_d;
            app_rdy_q   <= app_rdy_d;
            rx_done_q   <= rx_done;
        end
    end

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        txv_d       = txv_q;
        snd_d       = snd_q;
        rcv_d       = rcv_q;
        rcv_tmp     = rcv_q;
        peer_ip_d   = peer_ip_q;
        peer_port_d = peer_port_q;
        commit_d    = 1'b0;
        discard_d   = 1'b0;
        app_rdy_d   = 1'b0;
        go_listen   = 1'b0;
        est         = 1'b0;

        // A completing handshake advances snd_nxt before this cycle's segment is judged.
        if (txv_q && tx_ready) begin
            snd_d = snd_q + 32'(hdr_q.len);
            txv_d = 1'b0;
            hdr_d = '0;
        end

        if (timed && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            go_listen = 1'b1;
            discard_d = seg_evt;
        end else if (seg_evt) begin
            if (rx_err || rx_dest_port != LOCAL_PORT || (txv_q && !tx_ready) ||
                (state_q != LISTEN &&
                 (rx_src_ip != peer_ip_q || rx_source_port != peer_port_q))) begin
                discard_d = 1'b1;
            end else begin
                case (state_q)
                    LISTEN: begin
                        if (f_syn && !f_ack && !f_rst) begin
                            peer_ip_d   = rx_src_ip;
                            peer_port_d = rx_source_port;
                            rcv_d       = rx_seq + 32'd1;
                            hdr_d       = '{F_SYN | F_ACK, ISS, rx_seq + 32'd1,
                                            rx_src_ip, rx_source_port, 16'd0};
                            txv_d       = 1'b1;
                            snd_d       = ISS + 32'd1;
                            state_d     = SYN_RCVD;
                        end else begin
                            discard_d = 1'b1;
                        end
                    end
                    SYN_RCVD: begin
                        if (f_rst) begin
                            go_listen = 1'b1;
                            discard_d = 1'b1;
                        end else if (f_ack && rx_ack == snd_d) begin
                            est = 1'b1;
                        end else begin
                            discard_d = 1'b1;
                        end
                    end
                    ESTABLISHED: est = 1'b1;
                    LAST_ACK: begin
                        if (f_ack && rx_ack == snd_d) go_listen = 1'b1;
                        else                          discard_d = 1'b1;
                    end
                    default: go_listen = 1'b1;
                endcase

                if (est) begin
                    state_d = ESTABLISHED;
                    if (rx_seq != rcv_q) begin
                        discard_d = 1'b1;
                        hdr_d     = '{F_ACK, snd_d, rcv_q, peer_ip_q, peer_port_q, 16'd0};
                        txv_d     = 1'b1;
                    end else if (f_rst) begin
                        go_listen = 1'b1;
                        discard_d = 1'b1;
                    end else begin
                        rcv_tmp  = rcv_q + 32'(rx_data_len);
                        commit_d = (rx_data_len != 16'd0);
                        if (f_fin) begin
                            rcv_tmp = rcv_tmp + 32'd1;
                            hdr_d   = '{F_FIN | F_ACK, snd_d, rcv_tmp, peer_ip_q, peer_port_q, 16'd0};
                            txv_d   = 1'b1;
                            snd_d   = snd_d + 32'd1;
                            state_d = LAST_ACK;
                        end else if (rx_data_len != 16'd0) begin
                            hdr_d = '{F_ACK, snd_d, rcv_tmp, peer_ip_q, peer_port_q, 16'd0};
                            txv_d = 1'b1;
                        end
                        rcv_d = rcv_tmp;
                    end
                end
            end
        end else if (state_q == ESTABLISHED && !txv_q && app_tx_valid) begin
            app_rdy_d = 1'b1;
            hdr_d     = '{F_PSH | F_ACK, snd_q, rcv_q, peer_ip_q, peer_port_q, app_tx_len};
            txv_d     = 1'b1;
        end

        if (go_listen) begin
            state_d     = LISTEN;
            peer_ip_d   = '0;
            peer_port_d = '0;
            txv_d       = 1'b0;
            hdr_d       = '0;
            snd_d       = ISS;
        end

        timer_d = (state_d == state_q && timed) ? timer_q + TW'(1) : '0;
    end

    assign rx_commit    = commit_q;
    assign rx_discard   = discard_q;
    assign app_tx_ready = app_rdy_q;
    assign tx_valid     = txv_q;
    assign tx_flags     = hdr_q.flags;
    assign tx_seq       = hdr_q.seq;
    assign tx_ack_num   = hdr_q.ack;
    assign tx_dest_ip   = hdr_q.ip;
    assign tx_dest_port = hdr_q.port;
    assign tx_len       = hdr_q.len;
    assign conn_state   = state_q;
endmodule
